// File: rtl/onehot_decoder_pkg.sv
// Shared types and helpers for the registered binary-to-one-hot decoder.
// Decode results are sized for the widest legal configuration; callers slice.
package onehot_decoder_pkg;

    localparam int unsigned MAX_WIDTH = 256;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] onehot;
        logic                 error;
    } payload_t;

    function automatic int idx_width(input int unsigned width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Out-of-range indices yield an all-zero vector with the error bit set.
    function automatic payload_t decode_onehot(input int unsigned idx, input int unsigned width);
        payload_t p;
        p = '0;
        if (idx < width)
            p.onehot = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << idx;
        else
            p.error = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/decoder_skid_buffer.sv
// Two-entry valid/ready skid stage: OUT drives the master side, SKID catches
// the one beat accepted while OUT is stalled. s_ready comes from a register.
module decoder_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic              out_vld, skid_vld;
    logic [DATA_W-1:0] out_data, skid_data;
    logic              s_fire, m_fire;

    assign s_ready = ~rst & ~skid_vld;
    assign m_valid = out_vld;
    assign m_data  = out_data;
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = out_vld & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            skid_vld  <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else if (m_fire || !out_vld) begin
            // OUT is free after this edge: refill from SKID first to keep FIFO order.
            if (skid_vld) begin
                out_data <= skid_data;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else if (s_fire) begin
                out_data <= s_data;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end else if (s_fire) begin
            skid_data <= s_data;
            skid_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/onehot_decoder_reg.sv
// Registered binary-to-one-hot decoder with out-of-range flagging and a
// sticky error bit; storage and handshakes live in the skid stage.
module onehot_decoder_reg
    import onehot_decoder_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int          IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] s_index,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_onehot,
    output logic             m_error,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err_sticky,
    input  logic             err_clear
);

    payload_t dec;

    assign dec = decode_onehot(32'(s_index), WIDTH);

    // Bits above WIDTH are constant zero by construction.
    if (WIDTH < MAX_WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = |dec.onehot[MAX_WIDTH-1:WIDTH];
    end

    decoder_skid_buffer #(
        .DATA_W (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .s_data  ({dec.onehot[WIDTH-1:0], dec.error}),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  ({m_onehot, m_error}),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    // A new error on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (rst)
            err_sticky <= 1'b0;
        else if (s_valid && s_ready && dec.error)
            err_sticky <= 1'b1;
        else if (err_clear)
            err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Directed and randomised checks of onehot_decoder_reg at WIDTH 4, 6, 1 and 8.
module tb_onehot_decoder_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [263:0] got, input logic [263:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // WIDTH=4
    logic [1:0] s_index_4 = '0;
    logic       s_valid_4 = 0, m_ready_4 = 0, err_clear_4 = 0;
    logic       s_ready_4, m_error_4, m_valid_4, err_sticky_4;
    logic [3:0] m_onehot_4;
    onehot_decoder_reg #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .s_index(s_index_4), .s_valid(s_valid_4), .s_ready(s_ready_4),
        .m_onehot(m_onehot_4), .m_error(m_error_4), .m_valid(m_valid_4), .m_ready(m_ready_4),
        .err_sticky(err_sticky_4), .err_clear(err_clear_4));

    // WIDTH=6
    logic [2:0] s_index_6 = '0;
    logic       s_valid_6 = 0, m_ready_6 = 0, err_clear_6 = 0;
    logic       s_ready_6, m_error_6, m_valid_6, err_sticky_6;
    logic [5:0] m_onehot_6;
    onehot_decoder_reg #(.WIDTH(6)) dut6 (
        .clk(clk), .rst(rst), .s_index(s_index_6), .s_valid(s_valid_6), .s_ready(s_ready_6),
        .m_onehot(m_onehot_6), .m_error(m_error_6), .m_valid(m_valid_6), .m_ready(m_ready_6),
        .err_sticky(err_sticky_6), .err_clear(err_clear_6));

    // WIDTH=1
    logic s_index_1 = 0, s_valid_1 = 0, m_ready_1 = 0, err_clear_1 = 0;
    logic s_ready_1, m_error_1, m_valid_1, err_sticky_1;
    logic m_onehot_1;
    onehot_decoder_reg #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .s_index(s_index_1), .s_valid(s_valid_1), .s_ready(s_ready_1),
        .m_onehot(m_onehot_1), .m_error(m_error_1), .m_valid(m_valid_1), .m_ready(m_ready_1),
        .err_sticky(err_sticky_1), .err_clear(err_clear_1));

    // WIDTH=8
    logic [2:0] s_index_8 = '0;
    logic       s_valid_8 = 0, m_ready_8 = 0, err_clear_8 = 0;
    logic       s_ready_8, m_error_8, m_valid_8, err_sticky_8;
    logic [7:0] m_onehot_8;
    onehot_decoder_reg #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .s_index(s_index_8), .s_valid(s_valid_8), .s_ready(s_ready_8),
        .m_onehot(m_onehot_8), .m_error(m_error_8), .m_valid(m_valid_8), .m_ready(m_ready_8),
        .err_sticky(err_sticky_8), .err_clear(err_clear_8));

    localparam int N_BEATS = 10000;
    logic [7:0] exp_q[$];
    logic [7:0] held_v, exp8;
    logic [3:0] exp4;
    logic       held;
    int         sent, got, cyc;

    initial begin
        tick();
        tick();
        chk("rst_m_valid",    m_valid_4,    1'b0);
        chk("rst_s_ready",    s_ready_4,    1'b0);
        chk("rst_onehot",     m_onehot_4,   4'b0);
        chk("rst_err_sticky", err_sticky_4, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_release_s_ready", s_ready_4, 1'b1);

        // Back-to-back stream, latency 1
        m_ready_4 = 1'b1;
        s_valid_4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_index_4 = 2'(i);
            tick();
            exp4 = 4'b0001 << i;
            chk("w4_onehot",  m_onehot_4, exp4);
            chk("w4_m_valid", m_valid_4,  1'b1);
            chk("w4_s_ready", s_ready_4,  1'b1);
        end
        s_valid_4 = 1'b0;
        tick();
        chk("w4_drain", m_valid_4, 1'b0);

        // Backpressure: 2 then 3 with m_ready low
        m_ready_4 = 1'b0;
        s_valid_4 = 1'b1;
        s_index_4 = 2'd2;
        tick();
        chk("bp_s_ready_one", s_ready_4, 1'b1);
        s_index_4 = 2'd3;
        tick();
        s_valid_4 = 1'b0;
        chk("bp_s_ready_full", s_ready_4,  1'b0);
        chk("bp_hold_a",       m_onehot_4, 4'b0100);
        tick();
        chk("bp_hold_b", {m_valid_4, m_onehot_4}, {1'b1, 4'b0100});
        m_ready_4 = 1'b1;
        #1;
        chk("bp_first",       m_onehot_4, 4'b0100);
        chk("bp_s_ready_low", s_ready_4,  1'b0);
        tick();
        chk("bp_second",       {m_valid_4, m_onehot_4}, {1'b1, 4'b1000});
        chk("bp_s_ready_back", s_ready_4, 1'b1);
        tick();
        chk("bp_drain", m_valid_4, 1'b0);

        // WIDTH=6 range errors and sticky flag
        m_ready_6 = 1'b1;
        s_valid_6 = 1'b1;
        s_index_6 = 3'd5;
        tick();
        chk("w6_idx5",        {m_error_6, m_onehot_6}, {1'b0, 6'b100000});
        chk("w6_sticky_idle", err_sticky_6, 1'b0);
        s_index_6 = 3'd7;
        tick();
        chk("w6_idx7",        {m_valid_6, m_error_6, m_onehot_6}, {1'b1, 1'b1, 6'b0});
        chk("w6_sticky_set",  err_sticky_6, 1'b1);
        s_index_6   = 3'd6;
        err_clear_6 = 1'b1;
        tick();
        chk("w6_idx6",        {m_error_6, m_onehot_6}, {1'b1, 6'b0});
        chk("w6_set_wins",    err_sticky_6, 1'b1);
        s_valid_6   = 1'b0;
        err_clear_6 = 1'b0;
        tick();
        err_clear_6 = 1'b1;
        tick();
        err_clear_6 = 1'b0;
        chk("w6_cleared",     err_sticky_6, 1'b0);

        // WIDTH=1
        m_ready_1 = 1'b1;
        s_valid_1 = 1'b1;
        s_index_1 = 1'b0;
        tick();
        chk("w1_idx0", {m_valid_1, m_error_1, m_onehot_1}, 3'b101);
        s_index_1 = 1'b1;
        tick();
        chk("w1_idx1", {m_valid_1, m_error_1, m_onehot_1}, 3'b110);
        chk("w1_sticky", err_sticky_1, 1'b1);
        s_valid_1 = 1'b0;
        tick();

        // WIDTH=8 random valid/ready against a queue of reference decodes
        sent = 0;
        got  = 0;
        cyc  = 0;
        held = 1'b0;
        held_v = '0;
        while (got < N_BEATS && cyc < 60000) begin
            s_valid_8 = (sent < N_BEATS) && ($urandom_range(0, 3) != 0);
            s_index_8 = 3'($urandom_range(0, 7));
            m_ready_8 = ($urandom_range(0, 3) != 0);
            if (m_valid_8 && m_ready_8) begin
                if (exp_q.size() == 0) begin
                    chk("rand_spurious", 1'b1, 1'b0);
                end else begin
                    exp8 = exp_q.pop_front();
                    chk("rand_beat", {m_error_8, m_onehot_8}, {1'b0, exp8});
                end
                got++;
            end
            if (s_valid_8 && s_ready_8) begin
                exp_q.push_back(8'b1 << s_index_8);
                sent++;
            end
            held   = m_valid_8 && !m_ready_8;
            held_v = m_onehot_8;
            tick();
            cyc++;
            if (held)
                chk("rand_stable", {m_valid_8, m_onehot_8}, {1'b1, held_v});
        end
        s_valid_8 = 1'b0;
        chk("rand_done", 32'(got), 32'(N_BEATS));
        chk("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset from FULL with err_sticky set
        m_ready_6 = 1'b0;
        s_valid_6 = 1'b1;
        s_index_6 = 3'd7;
        tick();
        s_index_6 = 3'd6;
        tick();
        chk("pre_rst_full",   s_ready_6,    1'b0);
        chk("pre_rst_sticky", err_sticky_6, 1'b1);
        rst       = 1'b1;
        s_index_6 = 3'd2;
        m_ready_6 = 1'b1;
        tick();
        chk("rst_full_m_valid", m_valid_6,    1'b0);
        chk("rst_full_onehot",  {m_error_6, m_onehot_6}, 7'b0);
        chk("rst_full_sticky",  err_sticky_6, 1'b0);
        chk("rst_full_s_ready", s_ready_6,    1'b0);
        tick();
        chk("rst_ignore_in", m_valid_6, 1'b0);
        s_valid_6 = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_full_release", s_ready_6, 1'b1);
        tick();
        chk("rst_no_stale", m_valid_6, 1'b0);
        tick();
        chk("rst_no_stale2", m_valid_6, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/onehot_decoder_reg.md
# onehot_decoder_reg

Registered binary-to-one-hot decoder with valid/ready handshakes on both sides; the inverse of the team's priority encoder. It takes an encoded index stream (arbiter grants, channel selects) and produces a WIDTH-bit one-hot vector for downstream enable/select logic. Out-of-range indices are flagged, and a two-entry skid stage provides full throughput under backpressure.

## Interface
- WIDTH, 4, number of one-hot output bits; legal values are 1..256, and non-power-of-two values are allowed.
- IDX_W, derived as max(1, $clog2(WIDTH)); not overridable.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-high.
- s_index  in  IDX_W  encoded index, LSB = bit 0 of the output.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- m_onehot  out  WIDTH  decoded vector.
- m_error  out  1  this output beat came from an out-of-range index.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- err_sticky  out  1  at least one out-of-range beat accepted since the last clear.
- err_clear  in  1  clears err_sticky; single-cycle pulse.

## Operation
- Input accept: s_valid & s_ready. Output transfer: m_valid & m_ready.
- Decode: m_onehot = 1 << s_index when s_index < WIDTH.
- Out-of-range index (s_index >= WIDTH): m_onehot = 0 and m_error = 1. The beat is still forwarded, never dropped.
- WIDTH=1: s_index is 1 bit. Index 0 gives m_onehot=1. Index 1 is out of range.
- Storage consists of an output register (OUT) and a skid register (SKID). Each holds onehot, error and valid.
- States, derived from the valid bits:
  - EMPTY: neither register holds data.
  - ONE: OUT holds data, SKID is empty.
  - FULL: both registers hold data.
- EMPTY, accept → ONE.
- ONE, accept, no transfer → FULL (beat goes to SKID).
- ONE, accept and transfer together → ONE (OUT reloads with the new beat).
- ONE, transfer only → EMPTY.
- FULL, transfer → ONE (SKID moves to OUT). No accept is possible in FULL.
- s_ready = ~rst & ~SKID.valid. It is driven from a register and never depends combinationally on m_ready.
- Ordering is strictly FIFO. No beat is lost or duplicated.
- m_onehot and m_error hold stable while m_valid & ~m_ready.
- err_sticky is set on accept of an out-of-range beat and cleared by err_clear. If set and clear fall in the same cycle, set wins.

## Timing
- Latency: a beat accepted at edge N is presented on m_* after edge N.
- Throughput: 1 beat/cycle with m_ready held high.
- After a stall, s_ready rises the cycle after the FULL→ONE transfer.
- Reset, including when asserted mid-operation, clears within one edge:
  - all valid bits = 0, so m_valid = 0;
  - m_onehot = 0, m_error = 0, err_sticky = 0;
  - s_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- In-flight beats are discarded on reset.
- Inputs are ignored while rst is high.

## Structure
- Package onehot_decoder_pkg holds:
  - function idx_width(width), returning max(1, $clog2(width));
  - function decode_onehot(idx, width), returning the vector and the out-of-range bit;
  - a typedef for the stage payload struct (onehot, error).
- Sub-module decoder_skid_buffer: a generic two-entry valid/ready skid stage, parameterised on payload width. The top level contains only the decode function, the error logic and one skid instance.
- Expected size is about 150–250 lines of RTL in total.

## Test plan
- WIDTH=4, m_ready=1, indices 0,1,2,3 on back-to-back cycles → m_onehot 0001, 0010, 0100, 1000 on consecutive cycles; latency 1; s_ready stays 1.
- WIDTH=6, index 7 → m_onehot=000000, m_error=1, err_sticky=1 on the next cycle.
  - err_clear pulsed in the same cycle as a second index-6 accept → err_sticky stays 1.
  - A later lone err_clear → err_sticky=0.
- WIDTH=4, m_ready=0, send indices 2 then 3:
  - s_ready drops after the second accept;
  - m_onehot holds 0100;
  - when m_ready rises, 0100 then 1000 are delivered, and s_ready returns to 1 one cycle later.
- WIDTH=8, random valid/ready toggling over 10k beats → the output sequence equals the reference-model decode of the input sequence, and m_* is stable while stalled.
- Reset with FULL state and err_sticky=1 → next cycle: m_valid=0, m_onehot=0, err_sticky=0, s_ready=0. s_ready=1 in the first cycle after rst deasserts, and no stale beat is emitted.
- WIDTH=1: index 0 → m_onehot=1, m_error=0; index 1 → m_onehot=0, m_error=1.
